pe_inner_ctrl: RTL and testbench

//  Sequencer for a column of binary-serial inner-product PEs. Turns one tile command
//  (reduction length K, optional weight reload) into the idx, mac_done, en_*/clr_* strobes.

---
 rtl/pe_ctrl_pkg.sv | 22 ++
 rtl/pe_ctrl_cnt.sv | 27 ++
 rtl/pe_inner_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pe_inner_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and default geometry for the inner-product PE column sequencer.
package pe_ctrl_pkg;

    localparam int unsigned PE_IDEPTH    = 3;
    localparam int unsigned PE_KWIDTH    = 8;
    localparam int unsigned PE_WLOAD_CYC = 4;
    localparam int unsigned PE_DRAIN_CYC = 8;
    localparam int unsigned MAC_CYC      = 1 << PE_IDEPTH;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        MAC,
        DRAIN,
        DONE
    } pe_ctrl_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pe_ctrl_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module pe_ctrl_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/pe_inner_ctrl.sv
// Tile sequencer for a column of binary-serial inner-product PEs: turns one
// command into idx / mac_done / enable / clear strobes, all registered.
module pe_inner_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned IDEPTH    = PE_IDEPTH,
    parameter int unsigned KWIDTH    = PE_KWIDTH,
    parameter int unsigned WLOAD_CYC = PE_WLOAD_CYC,
    parameter int unsigned DRAIN_CYC = PE_DRAIN_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KWIDTH-1:0] cmd_k,
    input  logic              cmd_wload,
    input  logic              abort,
    output logic [IDEPTH-1:0] idx,
    output logic              mac_done,
    output logic              en_i,
    output logic              clr_i,
    output logic              en_w,
    output logic              clr_w,
    output logic              en_o,
    output logic              clr_o,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PH_MAX = max_u(WLOAD_CYC, DRAIN_CYC);
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    pe_ctrl_state_t    state;
    logic              accept;
    logic              ph_load;
    logic              ph_dec;
    logic              ph_zero;
    logic [PH_W-1:0]   ph_val;
    logic              mac_dec;
    logic              mac_zero;
    logic [IDEPTH-1:0] idx_nxt;

    // Counter controls; the MAC counter holds "MACs remaining after this one".
    always_comb begin
        accept  = (state == IDLE) && cmd_ready && cmd_valid;
        ph_load = (accept && (cmd_k != '0) && cmd_wload)
                || ((state == MAC) && mac_done && mac_zero);
        ph_val  = (state == IDLE) ? PH_W'(WLOAD_CYC - 1) : PH_W'(DRAIN_CYC - 1);
        ph_dec  = ((state == WLOAD) || (state == DRAIN)) && !ph_zero;
        mac_dec = (state == MAC) && mac_done && !mac_zero;
        idx_nxt = idx + IDEPTH'(1);
    end

    pe_ctrl_cnt #(.WIDTH(PH_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero_c   (ph_zero)
    );

    pe_ctrl_cnt #(.WIDTH(KWIDTH)) u_mac_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (cmd_k - KWIDTH'(1)),
        .dec      (mac_dec),
        .zero_c   (mac_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            idx       <= '0;
            mac_done  <= 1'b0;
            en_i      <= 1'b0;
            clr_i     <= 1'b0;
            en_w      <= 1'b0;
            clr_w     <= 1'b0;
            en_o      <= 1'b0;
            clr_o     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= 1'b0;
            idx       <= '0;
            mac_done  <= 1'b0;
            en_i      <= 1'b0;
            clr_i     <= 1'b0;
            en_w      <= 1'b0;
            clr_w     <= 1'b0;
            en_o      <= 1'b0;
            clr_o     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_k == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (cmd_wload) begin
                            state <= WLOAD;
                            en_w  <= 1'b1;
                        end else begin
                            state <= MAC;
                            en_i  <= 1'b1;
                            en_o  <= 1'b1;
                            clr_o <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                WLOAD: begin
                    if (ph_zero) begin
                        state <= MAC;
                        en_i  <= 1'b1;
                        en_o  <= 1'b1;
                        clr_o <= 1'b1;
                    end else begin
                        en_w <= 1'b1;
                    end
                end
                MAC: begin
                    en_o <= 1'b1;
                    if (mac_done) begin
                        if (mac_zero) begin
                            state <= DRAIN;
                        end else begin
                            en_i <= 1'b1;
                        end
                    end else begin
                        idx      <= idx_nxt;
                        mac_done <= &idx_nxt;
                    end
                end
                DRAIN: begin
                    if (ph_zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        en_o <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Abort overrides everything: one clear cycle (parked in DONE without the pulse), then IDLE.
            if (abort && (state != IDLE)) begin
                state     <= DONE;
                cmd_ready <= 1'b0;
                idx       <= '0;
                mac_done  <= 1'b0;
                en_i      <= 1'b0;
                en_w      <= 1'b0;
                en_o      <= 1'b0;
                clr_i     <= 1'b1;
                clr_o     <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_inner_ctrl.sv
// Self-checking bench for pe_inner_ctrl: per-cycle expected strobe traces are
// queued when a command is driven and compared as the DUT produces them.
module tb_pe_inner_ctrl;
    import pe_ctrl_pkg::*;

    typedef struct packed {
        logic                 cmd_ready;
        logic                 busy;
        logic                 done;
        logic [PE_IDEPTH-1:0] idx;
        logic                 mac_done;
        logic                 en_i;
        logic                 clr_i;
        logic                 en_w;
        logic                 clr_w;
        logic                 en_o;
        logic                 clr_o;
    } out_t;

    // ab: -1 none, -2 abort asserted together with the command in IDLE, >=0 abort in that tile cycle
    typedef struct {
        int k;
        bit wload;
        int ab;
        bit keep;
        int exp_busy;
    } vec_t;

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [PE_KWIDTH-1:0] cmd_k;
    logic                 cmd_wload;
    logic                 abort;
    logic [PE_IDEPTH-1:0] idx;
    logic                 mac_done;
    logic                 en_i;
    logic                 clr_i;
    logic                 en_w;
    logic                 clr_w;
    logic                 en_o;
    logic                 clr_o;
    logic                 busy;
    logic                 done;
    out_t                 cur;

    out_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    pe_inner_ctrl #(
        .IDEPTH    (PE_IDEPTH),
        .KWIDTH    (PE_KWIDTH),
        .WLOAD_CYC (PE_WLOAD_CYC),
        .DRAIN_CYC (PE_DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_k     (cmd_k),
        .cmd_wload (cmd_wload),
        .abort     (abort),
        .idx       (idx),
        .mac_done  (mac_done),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .en_w      (en_w),
        .clr_w     (clr_w),
        .en_o      (en_o),
        .clr_o     (clr_o),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cur = {cmd_ready, busy, done, idx, mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o};

    task automatic check(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy/busy/done/idx/md/ei/ci/ew/cw/eo/co=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic out_t idle_o();
        out_t o = '0;
        o.cmd_ready = 1'b1;
        return o;
    endfunction

    function automatic out_t busy_o();
        out_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    // Expected cycle-by-cycle outputs of one tile, from first cycle after accept through IDLE.
    task automatic gen_tile(input int k, input bit w);
        out_t o;
        if (w && k != 0) begin
            for (int c = 0; c < int'(PE_WLOAD_CYC); c++) begin
                o = busy_o();
                o.en_w = 1'b1;
                sb.push_back(o);
            end
        end
        for (int m = 0; m < k; m++) begin
            for (int b = 0; b < int'(MAC_CYC); b++) begin
                o          = busy_o();
                o.idx      = PE_IDEPTH'(b);
                o.en_i     = (b == 0);
                o.en_o     = 1'b1;
                o.clr_o    = (m == 0) && (b == 0);
                o.mac_done = (b == int'(MAC_CYC) - 1);
                sb.push_back(o);
            end
        end
        if (k != 0) begin
            for (int c = 0; c < int'(PE_DRAIN_CYC); c++) begin
                o = busy_o();
                o.en_o = 1'b1;
                sb.push_back(o);
            end
        end
        o = busy_o();
        o.done = 1'b1;
        sb.push_back(o);
        sb.push_back(idle_o());
    endtask

    task automatic run_tile(input int k, input bit w, input bit keep, input int ab, input int exp_busy);
        out_t e;
        out_t clr;
        int   cyc   = 0;
        int   nbusy = 0;
        check_int($sformatf("cmd_ready_before_k%0d", k), int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_k     = PE_KWIDTH'(k);
        cmd_wload = w;
        if (ab == -2) abort = 1'b1;
        gen_tile(k, w);
        if (ab >= 0) begin
            while (sb.size() > ab + 1) void'(sb.pop_back());
            clr       = busy_o();
            clr.clr_i = 1'b1;
            clr.clr_o = 1'b1;
            sb.push_back(clr);
            sb.push_back(idle_o());
        end
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        abort = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("tile_k%0d_w%0d_cyc%0d", k, w, cyc), cur, e);
            if (cur.busy) nbusy++;
            if (cyc == ab) abort = 1'b1;
            if (sb.size() > 0) begin
                @(negedge clk);
                abort = 1'b0;
                cyc++;
            end
        end
        check_int($sformatf("busy_cycles_k%0d_w%0d", k, w), nbusy, exp_busy);
    endtask

    vec_t vecs[10];

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_k     = '0;
        cmd_wload = 1'b0;
        abort     = 1'b0;

        vecs[0] = '{k: 2,   wload: 1'b0, ab: -1, keep: 1'b0, exp_busy: 25};
        vecs[1] = '{k: 1,   wload: 1'b1, ab: -1, keep: 1'b0, exp_busy: 21};
        vecs[2] = '{k: 0,   wload: 1'b0, ab: -1, keep: 1'b0, exp_busy: 1};
        vecs[3] = '{k: 3,   wload: 1'b0, ab: 13, keep: 1'b0, exp_busy: 15};
        vecs[4] = '{k: 1,   wload: 1'b0, ab: -1, keep: 1'b0, exp_busy: 17};
        vecs[5] = '{k: 1,   wload: 1'b0, ab: -2, keep: 1'b0, exp_busy: 17};
        vecs[6] = '{k: 1,   wload: 1'b0, ab: -1, keep: 1'b1, exp_busy: 17};
        vecs[7] = '{k: 1,   wload: 1'b0, ab: -1, keep: 1'b0, exp_busy: 17};
        vecs[8] = '{k: 3,   wload: 1'b1, ab: -1, keep: 1'b0, exp_busy: 37};
        vecs[9] = '{k: 255, wload: 1'b0, ab: -1, keep: 1'b0, exp_busy: 2049};

        repeat (2) @(negedge clk);
        check("reset_outputs", cur, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cur, idle_o());

        for (int i = 0; i < 10; i++) begin
            run_tile(vecs[i].k, vecs[i].wload, vecs[i].keep, vecs[i].ab, vecs[i].exp_busy);
        end

        // Abort alone in IDLE is ignored
        abort = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_in_idle", cur, idle_o());
        end
        abort = 1'b0;

        // Reset held for 3 cycles in the middle of a MAC
        cmd_valid = 1'b1;
        cmd_k     = PE_KWIDTH'(2);
        cmd_wload = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_int("mid_mac_idx", int'(idx), 4);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_mid_tile", cur, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", cur, idle_o());
        @(negedge clk);
        check("no_done_after_reset", cur, idle_o());
        run_tile(1, 1'b0, 1'b0, -1, 17);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
